fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program counter and call-stack stage upstream of decode_unit. Drives prg_addr to the program cache.
//  Consumes decode's registered pc_jmp/pc_brx/pc_brxt/pc_call/pc_ret and I_field.
//  Returns jmp_rst/brx_rst so decode clears its one-shot control bits.
//  Architecture uses delay slots: instructions already fetched behind a redirect execute; no flush here.
// PARAMETERS
//  RESET_VECTOR  16'h0000  prg_addr after reset
//  STACK_DEPTH   16        return-address LIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  rst           in   1   synchronous reset, active-high
//  hazard        in   1   pipeline stall from data hazard; PC holds
//  p_cache_miss  in   1   program cache miss; PC holds
//  pc_jmp        in   1   jump request (decode)
//  pc_call       in   1   call request (decode)
//  pc_ret        in   1   return request (decode, self-clearing in decode)
//  pc_brx        in   1   conditional/unconditional branch request (decode)
//  pc_brxt       in   1   branch sense: 0 = take if cond true, 1 = take if cond false
//  brx_cond      in   1   selected status condition (N/Z/P per H_en/L_en), 0 for bra
//  I_field       in   10  branch offset, two's complement, relative to branch address
//  target_addr   in   16  jump/call target (AUX0 register value)
//  prg_addr      out  16  program fetch address
//  jmp_rst       out  1   one-cycle pulse: jmp/call consumed
//  brx_rst       out  1   one-cycle pulse: brx consumed (taken or not)
//  stack_ovf     out  1   sticky: push with stack full
//  stack_unf     out  1   sticky: pop with stack empty
// BEHAVIOUR
//  Reset: prg_addr=RESET_VECTOR, addr_d1=addr_d2=RESET_VECTOR, sp=0, jmp_rst=brx_rst=0, ovf=unf=0.
//  Address pipeline: addr_d1 = address of instr in decode I_reg; addr_d2 = address of instr whose
//   controls are on decode outputs. Both advance only when advance = ~hazard & ~p_cache_miss.
//  Sequential: advance -> prg_addr <= prg_addr+1 (16-bit wrap, FFFF->0000). Else prg_addr holds.
//  Redirects act regardless of stall; priority ret > call > jmp > brx. At most one is legal;
//   the lower-priority one still gets its rst pulse if simultaneous.
//   ret : prg_addr <= stack[sp-1]; sp--. Empty: prg_addr <= addr_d2+1, set stack_unf, sp stays 0.
//   call: push addr_d2+1; prg_addr <= target_addr; jmp_rst=1 next cycle.
//         Full: no write, sp holds, set stack_ovf, jump still taken.
//   jmp : prg_addr <= target_addr; jmp_rst=1 next cycle.
//   brx : taken = brx_cond ^ pc_brxt. If taken, prg_addr <= addr_d2 + sext16(I_field).
//         Else prg_addr follows sequential rule. brx_rst=1 next cycle.
//  jmp_rst/brx_rst are registered, high exactly one cycle per consumed request.
//   While pc_jmp/pc_brx is still high in the cycle rst is asserted, the request is not re-executed
//   (guard bit: request ignored while own rst output is 1).
//  Arithmetic: all adds 16-bit modulo; I_field sign-extended from bit 9.
//  Reset mid-operation overrides everything; stack contents undefined, sp=0.
//  ovf/unf clear only on rst.
// STRUCTURE
//  neonfox_pkg: ADDR_W=16, IFIELD_W=10, typedef logic[15:0] addr_t.
//  Sub-module call_stack: LIFO, push/pop/full/empty, data_out = top entry, registered sp.
//  fetch_unit holds PC, address pipeline, redirect mux, rst pulses.
// TESTING
//  rst 1 cycle, no stall, 5 cycles -> prg_addr 0000,0001..0005; jmp_rst=brx_rst=0.
//  pc_jmp=1, target_addr=1234 -> next prg_addr=1234, jmp_rst pulses 1 cycle;
//   no re-jump while pc_jmp still high.
//  addr_d2=0040, pc_brx=1, pc_brxt=0, brx_cond=1, I_field=3F0 (-16) -> prg_addr=0030;
//   brx_cond=0 -> sequential; brx_rst pulses in both cases.
//  call at addr_d2=0100, target 0800, then ret -> prg_addr 0800 then 0101; sp back to 0.
//  STACK_DEPTH+1 nested calls -> stack_ovf=1; ret on empty stack -> stack_unf=1.
//  hazard=1 or p_cache_miss=1 for 3 cycles -> prg_addr frozen; prg_addr=FFFF advances to 0000.

Source files
------------

// File: rtl/neonfox_pkg.sv
// Shared widths, address type and redirect selector for the fetch stage.
package neonfox_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned IFIELD_W = 10;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [IFIELD_W-1:0] ifield_t;

    // Source of the next program address, in decreasing priority after SEL_SEQ.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_RET,
        SEL_CALL,
        SEL_JMP,
        SEL_BRX
    } redirect_e;

    // Branch offsets are two's complement, sign bit is the top bit of I_field.
    function automatic addr_t sext_ifield(input ifield_t f);
        return {{(ADDR_W - IFIELD_W){f[IFIELD_W-1]}}, f};
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO: registered stack pointer, top entry always visible.
module call_stack
    import neonfox_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW:0] sp_t;

    sp_t           sp;
    logic [PW-1:0] top_idx;
    addr_t         mem [DEPTH];

    assign full     = (sp == sp_t'(DEPTH));
    assign empty    = (sp == '0);
    // Wraps to DEPTH-1 when empty; the caller ignores data_out in that case.
    assign top_idx  = sp[PW-1:0] - PW'(1);
    assign data_out = mem[top_idx];

    // Storage write on a push with room; contents are not reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[PW-1:0]] <= data_in;
        end
    end

    // Stack pointer: push and pop are never requested together by the fetch unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + sp_t'(1);
        end else if (pop && !empty) begin
            sp <= sp - sp_t'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, decode-side address pipeline, redirect mux and consume pulses.
module fetch_unit
    import neonfox_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned       STACK_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard,
    input  logic                p_cache_miss,
    input  logic                pc_jmp,
    input  logic                pc_call,
    input  logic                pc_ret,
    input  logic                pc_brx,
    input  logic                pc_brxt,
    input  logic                brx_cond,
    input  logic [IFIELD_W-1:0] I_field,
    input  logic [ADDR_W-1:0]   target_addr,
    output logic [ADDR_W-1:0]   prg_addr,
    output logic                jmp_rst,
    output logic                brx_rst,
    output logic                stack_ovf,
    output logic                stack_unf
);

    addr_t     addr_d1;
    addr_t     addr_d2;
    addr_t     next_addr;
    addr_t     seq_addr;
    addr_t     link_addr;
    addr_t     stk_top;
    logic      advance;
    logic      ret_req;
    logic      call_req;
    logic      jmp_req;
    logic      brx_req;
    logic      brx_taken;
    logic      stk_push;
    logic      stk_pop;
    logic      stk_full;
    logic      stk_empty;
    redirect_e sel;

    assign advance   = ~hazard & ~p_cache_miss;
    assign seq_addr  = advance ? prg_addr + addr_t'(1) : prg_addr;
    assign link_addr = addr_d2 + addr_t'(1);

    // A request still held high while its own consume pulse is out was already serviced.
    assign ret_req   = pc_ret;
    assign call_req  = pc_call & ~jmp_rst;
    assign jmp_req   = pc_jmp  & ~jmp_rst;
    assign brx_req   = pc_brx  & ~brx_rst;
    assign brx_taken = brx_req & (brx_cond ^ pc_brxt);

    // Redirect priority: ret > call > jmp > taken branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (ret_req) begin
            sel = SEL_RET;
        end else if (call_req) begin
            sel = SEL_CALL;
        end else if (jmp_req) begin
            sel = SEL_JMP;
        end else if (brx_taken) begin
            sel = SEL_BRX;
        end
    end

    // Next fetch address for the selected source.
    always_comb begin
        next_addr = seq_addr;
        unique case (sel)
            SEL_RET:  next_addr = stk_empty ? link_addr : stk_top;
            SEL_CALL: next_addr = target_addr;
            SEL_JMP:  next_addr = target_addr;
            SEL_BRX:  next_addr = addr_d2 + sext_ifield(I_field);
            default:  next_addr = seq_addr;
        endcase
    end

    assign stk_push = (sel == SEL_CALL);
    assign stk_pop  = (sel == SEL_RET);

    // Program counter: redirects apply even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prg_addr <= RESET_VECTOR;
        end else begin
            prg_addr <= next_addr;
        end
    end

    // Addresses of the instructions in decode's I_reg and on decode's control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_d1 <= RESET_VECTOR;
            addr_d2 <= RESET_VECTOR;
        end else if (advance) begin
            addr_d1 <= prg_addr;
            addr_d2 <= addr_d1;
        end
    end

    // One-cycle consume pulses; a lower-priority request still gets its pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            jmp_rst <= 1'b0;
            brx_rst <= 1'b0;
        end else begin
            jmp_rst <= call_req | jmp_req;
            brx_rst <= brx_req;
        end
    end

    // Sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (stk_push && stk_full) begin
                stack_ovf <= 1'b1;
            end
            if (stk_pop && stk_empty) begin
                stack_unf <= 1'b1;
            end
        end
    end

    call_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (link_addr),
        .data_out (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

endmodule
